// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and the instruction-cache address split.
package cpu_types_pkg;

  localparam int WORD_W       = 32;
  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = WORD_W - ICACHE_IDX_W - 2;

  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

endpackage

// File: rtl/icache_frame_array.sv
// Direct-mapped frame storage: valid/tag/data per set, one write port,
// one combinational read port and a clear-all of the valid bits.
module icache_frame_array
  import cpu_types_pkg::*;
#(
  parameter int SETS  = ICACHE_SETS,
  parameter int TAG_W = ICACHE_TAG_W,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [TAG_W-1:0] wtag,
  input  word_t            wdata,
  input  logic [IDX_W-1:0] ridx,
  output logic             rvalid,
  output logic [TAG_W-1:0] rtag,
  output word_t            rdata
);

  logic [SETS-1:0] valid;
  logic [TAG_W-1:0] tag_mem [SETS];
  word_t            data_mem [SETS];

  // A clear on the same edge as a write wins, leaving the written frame invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (we)    valid[widx] <= 1'b1;
      if (clear) valid       <= '0;
    end
  end

  // NOTE: tag/data arrays are deliberately not reset; valid masks every read,
  // and leaving them reset-free lets them map to plain storage.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[widx]  <= wtag;
      data_mem[widx] <= wdata;
    end
  end

  assign rvalid = valid[ridx];
  assign rtag   = tag_mem[ridx];
  assign rdata  = data_mem[ridx];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-block instruction cache with a two-state miss
// FSM toward the memory controller, flush and saturating hit/miss counters.
module icache
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  imemREN,
  input  word_t imemaddr,
  input  logic  flush,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload,
  output word_t hit_count,
  output word_t miss_count
);

  typedef enum logic {IDLE, MISS} icache_state_t;

  icache_state_t state;
  word_t         miss_addr;
  icachef_t      req, fill;

  logic                    f_valid;
  logic [ICACHE_TAG_W-1:0] f_tag;
  word_t                   f_data;
  logic                    hit, miss_start, fill_en;
  logic                    unused_bytoff;

  assign req  = icachef_t'(imemaddr);
  assign fill = icachef_t'(miss_addr);
  assign unused_bytoff = ^{req.bytoff, fill.bytoff};

  icache_frame_array #(
    .SETS  (ICACHE_SETS),
    .TAG_W (ICACHE_TAG_W)
  ) u_frames (
    .clk    (CLK),
    .rst    (RST),
    .clear  (flush),
    .we     (fill_en),
    .widx   (fill.idx),
    .wtag   (fill.tag),
    .wdata  (iload),
    .ridx   (req.idx),
    .rvalid (f_valid),
    .rtag   (f_tag),
    .rdata  (f_data)
  );

  // A flush cycle never hits, so a request alongside flush becomes a forced miss.
  assign hit        = (state == IDLE) && imemREN && f_valid && (f_tag == req.tag) && !flush;
  assign miss_start = (state == IDLE) && imemREN && !hit;
  assign fill_en    = (state == MISS) && !iwait;

  assign ihit     = hit;
  assign imemload = hit ? f_data : '0;
  assign iREN     = (state == MISS);
  assign iaddr    = (state == MISS) ? miss_addr : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      miss_addr  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: if (miss_start) begin
          state     <= MISS;
          miss_addr <= imemaddr;
        end
        MISS: if (!iwait) state <= IDLE;
      endcase
      if (hit && hit_count != '1)         hit_count  <= hit_count + 32'd1;
      if (miss_start && miss_count != '1) miss_count <= miss_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus a randomized run,
// all compared against a frame-map reference model kept in the bench.
module tb_icache;
  import cpu_types_pkg::*;

  localparam longint MAXC = 64'h0000_0000_FFFF_FFFF;

  logic  CLK = 1'b0;
  logic  RST, imemREN, flush, iwait;
  word_t imemaddr, iload;
  logic  ihit, iREN;
  word_t imemload, iaddr, hit_count, miss_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: which full word address lives in each frame, plus the pending miss.
  bit     m_miss;
  word_t  m_maddr;
  bit     m_v [16];
  word_t  m_a [16];
  word_t  m_d [16];
  longint m_hits, m_misses;

  always #5 CLK = ~CLK;

  icache dut (
    .CLK        (CLK),
    .RST        (RST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .flush      (flush),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  function automatic int fidx(word_t a);
    return int'((a >> 2) % 16);
  endfunction

  function automatic bit exp_hit();
    int i = fidx(imemaddr);
    return !m_miss && imemREN && !flush && m_v[i] && (m_a[i] == imemaddr);
  endfunction

  function automatic word_t exp_load();
    return exp_hit() ? m_d[fidx(imemaddr)] : 32'h0;
  endfunction

  // Advance one clock: apply the cache rules to the current inputs, then let the DUT see the edge.
  task automatic tick();
    bit h = exp_hit();
    if (RST) begin
      m_miss = 0; m_maddr = '0; m_hits = 0; m_misses = 0;
      foreach (m_v[i]) m_v[i] = 0;
    end else begin
      if (!m_miss && imemREN && !h) begin
        m_miss = 1; m_maddr = imemaddr;
        if (m_misses < MAXC) m_misses++;
      end else if (m_miss && !iwait) begin
        m_a[fidx(m_maddr)] = m_maddr;
        m_d[fidx(m_maddr)] = iload;
        m_v[fidx(m_maddr)] = 1;
        m_miss = 0;
      end
      if (h && m_hits < MAXC) m_hits++;
      if (flush) foreach (m_v[i]) m_v[i] = 0;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1; imemREN = 0; imemaddr = '0; flush = 0; iwait = 1; iload = '0;
    tick(); tick();
    RST = 0;
    #1;
    n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL reset_ihit: got %0b want 0", ihit); end
    n_checks++; if (imemload !== 32'h0) begin n_fail++; $display("FAIL reset_imemload: got %h want 0", imemload); end
    n_checks++; if (iREN !== 1'b0) begin n_fail++; $display("FAIL reset_iREN: got %0b want 0", iREN); end
    n_checks++; if (iaddr !== 32'h0) begin n_fail++; $display("FAIL reset_iaddr: got %h want 0", iaddr); end
    n_checks++; if (hit_count !== 32'h0) begin n_fail++; $display("FAIL reset_hit_count: got %0d want 0", hit_count); end
    n_checks++; if (miss_count !== 32'h0) begin n_fail++; $display("FAIL reset_miss_count: got %0d want 0", miss_count); end
  endtask

  task automatic test_cold_miss();
    imemREN = 1; imemaddr = 32'h40; iwait = 1;
    #1;
    n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL cold_ihit: got %0b want 0", ihit); end
    tick();
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (iREN !== 1'b1 || iaddr !== 32'h40 || ihit !== 1'b0) begin
        n_fail++; $display("FAIL cold_miss_req: got iREN=%0b iaddr=%h ihit=%0b want 1/00000040/0", iREN, iaddr, ihit);
      end
      tick();
    end
    iwait = 0; iload = 32'h2408_0001;
    tick();
    iwait = 1; iload = '0;
    #1;
    n_checks++; if (ihit !== 1'b1 || imemload !== 32'h2408_0001) begin
      n_fail++; $display("FAIL cold_refetch: got ihit=%0b load=%h want 1/24080001", ihit, imemload);
    end
    n_checks++; if (miss_count !== 32'd1) begin n_fail++; $display("FAIL cold_miss_count: got %0d want 1", miss_count); end
  endtask

  task automatic test_hit_under_stall();
    tick();
    for (int c = 0; c < 4; c++) begin
      n_checks++; if (ihit !== 1'b1 || iREN !== 1'b0 || imemload !== 32'h2408_0001) begin
        n_fail++; $display("FAIL stall_hit: got ihit=%0b iREN=%0b load=%h want 1/0/24080001", ihit, iREN, imemload);
      end
      tick();
    end
    n_checks++; if (hit_count !== 32'd5) begin n_fail++; $display("FAIL stall_hit_count: got %0d want 5", hit_count); end
  endtask

  task automatic test_conflict();
    imemaddr = 32'h80;
    #1;
    n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL conflict_miss80: got ihit=%0b want 0", ihit); end
    tick();
    iwait = 0; iload = 32'hDEAD_BEEF;
    tick();
    iwait = 1;
    #1;
    n_checks++; if (ihit !== 1'b1 || imemload !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL conflict_hit80: got ihit=%0b load=%h want 1/deadbeef", ihit, imemload);
    end
    imemaddr = 32'h40;
    #1;
    n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL conflict_miss40: got ihit=%0b want 0", ihit); end
    tick();
    n_checks++; if (iREN !== 1'b1 || iaddr !== 32'h40) begin
      n_fail++; $display("FAIL conflict_req40: got iREN=%0b iaddr=%h want 1/00000040", iREN, iaddr);
    end
    iwait = 0; iload = 32'h2408_0001;
    tick();
    iwait = 1;
  endtask

  task automatic test_addr_change();
    imemaddr = 32'h44;
    tick();
    imemaddr = 32'h48;
    #1;
    n_checks++; if (iaddr !== 32'h44) begin n_fail++; $display("FAIL chg_iaddr_hold: got %h want 00000044", iaddr); end
    tick();
    iwait = 0; iload = 32'h1111_1144;
    #1;
    n_checks++; if (iaddr !== 32'h44) begin n_fail++; $display("FAIL chg_iaddr_fill: got %h want 00000044", iaddr); end
    tick();
    iwait = 1;
    #1;
    n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL chg_miss48: got ihit=%0b want 0", ihit); end
    tick();
    n_checks++; if (iREN !== 1'b1 || iaddr !== 32'h48) begin
      n_fail++; $display("FAIL chg_req48: got iREN=%0b iaddr=%h want 1/00000048", iREN, iaddr);
    end
    iwait = 0; iload = 32'h1111_1148;
    tick();
    iwait = 1; imemaddr = 32'h44;
    #1;
    n_checks++; if (ihit !== 1'b1 || imemload !== 32'h1111_1144) begin
      n_fail++; $display("FAIL chg_hit44: got ihit=%0b load=%h want 1/11111144", ihit, imemload);
    end
  endtask

  task automatic test_flush();
    imemaddr = 32'h40;
    #1;
    n_checks++; if (ihit !== 1'b1) begin n_fail++; $display("FAIL flush_prehit: got ihit=%0b want 1", ihit); end
    flush = 1;
    #1;
    n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL flush_forced_miss: got ihit=%0b want 0", ihit); end
    tick();
    flush = 0;
    #1;
    n_checks++; if (iREN !== 1'b1 || iaddr !== 32'h40) begin
      n_fail++; $display("FAIL flush_miss_state: got iREN=%0b iaddr=%h want 1/00000040", iREN, iaddr);
    end
    flush = 1; iwait = 0; iload = 32'h5555_AAAA;
    tick();
    flush = 0; iwait = 1;
    #1;
    n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL flush_on_fill: got ihit=%0b want 0", ihit); end
    tick();
    n_checks++; if (iREN !== 1'b1) begin n_fail++; $display("FAIL flush_refill_req: got iREN=%0b want 1", iREN); end
    iwait = 0; iload = 32'h6666_0040;
    tick();
    iwait = 1;
    #1;
    n_checks++; if (ihit !== 1'b1 || imemload !== 32'h6666_0040) begin
      n_fail++; $display("FAIL flush_refill_hit: got ihit=%0b load=%h want 1/66660040", ihit, imemload);
    end
    n_checks++; if (miss_count !== m_misses[31:0]) begin
      n_fail++; $display("FAIL flush_miss_count: got %0d want %0d", miss_count, m_misses);
    end
  endtask

  task automatic test_reset_mid_miss();
    imemaddr = 32'h300;
    tick();
    n_checks++; if (iREN !== 1'b1) begin n_fail++; $display("FAIL rstmiss_inmiss: got iREN=%0b want 1", iREN); end
    RST = 1;
    tick();
    RST = 0; imemREN = 0;
    #1;
    n_checks++; if (iREN !== 1'b0 || iaddr !== 32'h0 || ihit !== 1'b0 || imemload !== 32'h0) begin
      n_fail++; $display("FAIL rstmiss_outputs: got iREN=%0b iaddr=%h ihit=%0b load=%h want all 0", iREN, iaddr, ihit, imemload);
    end
    n_checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      n_fail++; $display("FAIL rstmiss_counters: got hit=%0d miss=%0d want 0/0", hit_count, miss_count);
    end
    imemREN = 1; imemaddr = 32'h40;
    #1;
    n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL rstmiss_prior_frame: got ihit=%0b want 0", ihit); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      RST      = ($urandom_range(0, 99) == 0);
      imemREN  = ($urandom_range(0, 3) != 0);
      imemaddr = (word_t'($urandom_range(0, 3)) << 6) | (word_t'($urandom_range(0, 3)) << 2);
      flush    = ($urandom_range(0, 15) == 0);
      iwait    = $urandom_range(0, 1);
      iload    = $urandom;
      #1;
      n_checks++; if (ihit !== exp_hit() || imemload !== exp_load()) begin
        n_fail++; $display("FAIL rand_lookup c=%0d: got ihit=%0b load=%h want %0b/%h", c, ihit, imemload, exp_hit(), exp_load());
      end
      n_checks++; if (iREN !== m_miss || iaddr !== (m_miss ? m_maddr : 32'h0)) begin
        n_fail++; $display("FAIL rand_req c=%0d: got iREN=%0b iaddr=%h want %0b/%h", c, iREN, iaddr, m_miss, m_miss ? m_maddr : 32'h0);
      end
      n_checks++; if (hit_count !== m_hits[31:0] || miss_count !== m_misses[31:0]) begin
        n_fail++; $display("FAIL rand_counters c=%0d: got hit=%0d miss=%0d want %0d/%0d", c, hit_count, miss_count, m_hits, m_misses);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit_under_stall();
    test_conflict();
    test_addr_change();
    test_flush();
    test_reset_mid_miss();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
